// File: rtl/sdi_xcvr_lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdi_xcvr_lock_pkg
//  Description : Shared types and constants for the SDI transceiver lock
//                monitor. Defines the link FSM state encoding, the CSR word
//                addresses and the bit positions inside STICKY and CTRL.
//  Revision    : 1.0  initial release
// ============================================================================
package sdi_xcvr_lock_pkg;

  // Link FSM states. The encoding is visible to software in STATUS[5:4].
  typedef enum logic [1:0] {
    DOWN    = 2'd0,
    QUALIFY = 2'd1,
    UP      = 2'd2,
    HOLDOFF = 2'd3
  } link_state_t;

  // CSR word addresses
  localparam logic [3:0] ADDR_STATUS = 4'd0;
  localparam logic [3:0] ADDR_STICKY = 4'd1;
  localparam logic [3:0] ADDR_LOSS   = 4'd2;
  localparam logic [3:0] ADDR_CTRL   = 4'd3;
  localparam logic [3:0] ADDR_UPTIME = 4'd4;

  // STICKY register bit positions
  localparam int STICKY_LOCK_LOST = 0;
  localparam int STICKY_PLL_LOST  = 1;

  // CTRL register bit positions
  localparam int CTRL_IRQ_EN       = 0;
  localparam int CTRL_FORCE_RELOCK = 1;

endpackage : sdi_xcvr_lock_pkg
`default_nettype wire

// File: rtl/sdi_xcvr_bit_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sdi_xcvr_bit_sync
//  Description : Two-flop synchronizer for a single asynchronous level.
//                Both flops clear on the synchronous active-high reset.
//  Revision    : 1.0  initial release
//  Ports       : clk    in   system clock
//                reset  in   synchronous, active-high reset
//                d      in   asynchronous input level
//                q      out  synchronized level (2 clk latency)
// ============================================================================
module sdi_xcvr_bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : sdi_xcvr_bit_sync
`default_nettype wire

// File: rtl/sdi_xcvr_lock_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : sdi_xcvr_lock_monitor
//  Description : Qualifies SDI transceiver lock status. Synchronizes the TX
//                PLL lock, CDR lock-to-ref and loopback-enable monitor, runs
//                a DOWN/QUALIFY/UP/HOLDOFF link FSM to produce a stable
//                link_up, counts loss-of-lock events and exposes status,
//                sticky flags, counters and control on an Avalon-MM slave.
//  Revision    : 1.0  initial release
//  Ports       : clk                  in   system clock
//                reset                in   synchronous, active-high reset
//                csr_address[3:0]     in   CSR word address
//                csr_read             in   read strobe
//                csr_write            in   write strobe
//                csr_readdata[31:0]   out  registered read data
//                csr_writedata[31:0]  in   write data
//                pll_locked           in   TX PLL lock (async)
//                rx_is_lockedtoref    in   CDR locked to reference (async)
//                rx_seriallpbken_mon  in   loopback-enable monitor (async)
//                link_up              out  qualified link status
//                lock_lost_irq        out  level interrupt
// ============================================================================
module sdi_xcvr_lock_monitor
  import sdi_xcvr_lock_pkg::*;
#(
  parameter int QUAL_CYCLES    = 1024,
  parameter int HOLDOFF_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  output logic [31:0] csr_readdata,
  input  logic [31:0] csr_writedata,
  input  logic        pll_locked,
  input  logic        rx_is_lockedtoref,
  input  logic        rx_seriallpbken_mon,
  output logic        link_up,
  output logic        lock_lost_irq
);

  localparam int QUAL_W = $clog2(QUAL_CYCLES);
  // +1 keeps the counter at least one bit wide when HOLDOFF_CYCLES is 1
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [QUAL_W-1:0] c_qual_last = QUAL_W'(QUAL_CYCLES - 1);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLDOFF_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Input synchronization: bit 0 = pll_locked, 1 = rx_is_lockedtoref,
  // 2 = rx_seriallpbken_mon
  // --------------------------------------------------------------------------
  logic [2:0] w_async_in;
  logic [2:0] w_sync_out;

  assign w_async_in = {rx_seriallpbken_mon, rx_is_lockedtoref, pll_locked};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      sdi_xcvr_bit_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (w_async_in[gi]),
        .q     (w_sync_out[gi])
      );
    end
  endgenerate

  logic w_p;
  logic w_r;
  logic w_m;

  assign w_p = w_sync_out[0];
  assign w_r = w_sync_out[1];
  assign w_m = w_sync_out[2];

  // Previous synced loopback monitor, for edge detection
  logic r_m_d;

  always_ff @(posedge clk) begin
    if (reset) r_m_d <= 1'b0;
    else       r_m_d <= w_m;
  end

  // --------------------------------------------------------------------------
  // CSR write decode
  // --------------------------------------------------------------------------
  logic w_wr_sticky;
  logic w_wr_loss;
  logic w_wr_ctrl;
  logic w_force;

  assign w_wr_sticky = csr_write && (csr_address == ADDR_STICKY);
  assign w_wr_loss   = csr_write && (csr_address == ADDR_LOSS);
  assign w_wr_ctrl   = csr_write && (csr_address == ADDR_CTRL);
  // force_relock is a write-time strobe only; it is never stored
  assign w_force     = w_wr_ctrl && csr_writedata[CTRL_FORCE_RELOCK];

  // Only the low two data bits carry meaning in any register
  logic w_unused_wdata;
  assign w_unused_wdata = ^csr_writedata[31:2];

  // --------------------------------------------------------------------------
  // Link FSM
  // --------------------------------------------------------------------------
  link_state_t       r_state;
  link_state_t       w_state_nxt;
  logic [QUAL_W-1:0] r_qual_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_lock;
  logic              w_m_edge;
  logic              w_qual_clr;
  logic              w_hold_clr;
  logic              w_up_entry;
  logic              w_loss;

  assign w_lock   = w_p && w_r;
  assign w_m_edge = w_m ^ r_m_d;

  always_ff @(posedge clk) begin
    if (reset) r_state <= DOWN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_qual_clr  = 1'b0;
    w_hold_clr  = 1'b0;
    w_up_entry  = 1'b0;
    w_loss      = 1'b0;
    case (r_state)
      DOWN: begin
        if (w_force) begin
          w_state_nxt = HOLDOFF;
          w_hold_clr  = 1'b1;
        end else if (w_lock) begin
          w_state_nxt = QUALIFY;
          w_qual_clr  = 1'b1;
        end
      end
      QUALIFY: begin
        if (!w_lock) begin
          w_state_nxt = DOWN;
        end else if (w_m_edge) begin
          // loopback mode changed: restart qualification from zero
          w_qual_clr  = 1'b1;
        end else if (w_force) begin
          w_state_nxt = HOLDOFF;
          w_hold_clr  = 1'b1;
        end else if (r_qual_cnt == c_qual_last) begin
          w_state_nxt = UP;
          w_up_entry  = 1'b1;
        end
      end
      UP: begin
        if (!w_lock) begin
          w_state_nxt = HOLDOFF;
          w_hold_clr  = 1'b1;
          w_loss      = 1'b1;
        end else if (w_m_edge) begin
          w_state_nxt = QUALIFY;
          w_qual_clr  = 1'b1;
        end else if (w_force) begin
          w_state_nxt = HOLDOFF;
          w_hold_clr  = 1'b1;
        end
      end
      HOLDOFF: begin
        if (w_force) begin
          // a fresh relock request restarts the holdoff window
          w_hold_clr  = 1'b1;
        end else if (r_hold_cnt == c_hold_last) begin
          w_state_nxt = DOWN;
        end
      end
      default: begin
        w_state_nxt = DOWN;
      end
    endcase
  end

  // Qualification and holdoff counters: cleared on (re-)entry, counting
  // every cycle spent in their state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_qual_cnt <= '0;
      r_hold_cnt <= '0;
    end else begin
      if (w_qual_clr)             r_qual_cnt <= '0;
      else if (r_state == QUALIFY) r_qual_cnt <= r_qual_cnt + 1'b1;

      if (w_hold_clr)             r_hold_cnt <= '0;
      else if (r_state == HOLDOFF) r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Uptime, loss counter, sticky flags, control
  // --------------------------------------------------------------------------
  logic [31:0]      r_uptime;
  logic [CNT_W-1:0] r_loss_cnt;
  logic [1:0]       r_sticky;
  logic             r_irq_en;
  logic [1:0]       w_sticky_set;
  logic [1:0]       w_sticky_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_uptime <= '0;
    end else if (w_up_entry) begin
      r_uptime <= '0;
    end else if ((r_state == UP) && (r_uptime != '1)) begin
      r_uptime <= r_uptime + 32'd1;
    end
  end

  // A loss arriving with a write-clear leaves exactly that loss counted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_loss_cnt <= '0;
    end else if (w_wr_loss) begin
      r_loss_cnt <= w_loss ? CNT_W'(1) : '0;
    end else if (w_loss && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + 1'b1;
    end
  end

  always_comb begin
    w_sticky_set                   = 2'b00;
    w_sticky_set[STICKY_LOCK_LOST] = w_loss;
    w_sticky_set[STICKY_PLL_LOST]  = w_loss && !w_p;
    w_sticky_clr                   = w_wr_sticky ? csr_writedata[1:0] : 2'b00;
  end

  // Set is OR-ed in after the clear so a simultaneous event wins
  always_ff @(posedge clk) begin
    if (reset) r_sticky <= 2'b00;
    else       r_sticky <= (r_sticky & ~w_sticky_clr) | w_sticky_set;
  end

  always_ff @(posedge clk) begin
    if (reset)          r_irq_en <= 1'b0;
    else if (w_wr_ctrl) r_irq_en <= csr_writedata[CTRL_IRQ_EN];
  end

  // --------------------------------------------------------------------------
  // CSR read path: registered, holds until the next read strobe
  // --------------------------------------------------------------------------
  logic [31:0] w_rd_mux;

  always_comb begin
    w_rd_mux = 32'd0;
    case (csr_address)
      ADDR_STATUS: w_rd_mux = {26'd0, r_state, w_m, w_r, w_p, link_up};
      ADDR_STICKY: w_rd_mux = {30'd0, r_sticky};
      ADDR_LOSS:   w_rd_mux = 32'(r_loss_cnt);
      ADDR_CTRL:   w_rd_mux = {31'd0, r_irq_en};
      ADDR_UPTIME: w_rd_mux = r_uptime;
      default:     w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)         csr_readdata <= 32'd0;
    else if (csr_read) csr_readdata <= w_rd_mux;
  end

  assign link_up       = (r_state == UP);
  assign lock_lost_irq = r_sticky[STICKY_LOCK_LOST] && r_irq_en;

endmodule : sdi_xcvr_lock_monitor
`default_nettype wire

// File: tb/tb_sdi_xcvr_lock_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdi_xcvr_lock_monitor
//  Description : Directed self-checking bench for sdi_xcvr_lock_monitor with
//                QUAL_CYCLES=16, HOLDOFF_CYCLES=8, CNT_W=4. All stimulus is
//                applied just after a falling edge; outputs are sampled there.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdi_xcvr_lock_monitor;
  import sdi_xcvr_lock_pkg::*;

  localparam int QUAL    = 16;
  localparam int HOLDOFF = 8;
  localparam int CNTW    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  csr_address = 4'd0;
  logic        csr_read = 1'b0;
  logic        csr_write = 1'b0;
  logic [31:0] csr_readdata;
  logic [31:0] csr_writedata = 32'd0;
  logic        pll_locked = 1'b0;
  logic        rx_is_lockedtoref = 1'b0;
  logic        rx_seriallpbken_mon = 1'b0;
  logic        link_up;
  logic        lock_lost_irq;

  int n_checks = 0;
  int n_errors = 0;

  sdi_xcvr_lock_monitor #(
    .QUAL_CYCLES    (QUAL),
    .HOLDOFF_CYCLES (HOLDOFF),
    .CNT_W          (CNTW)
  ) u_dut (
    .clk                 (clk),
    .reset               (reset),
    .csr_address         (csr_address),
    .csr_read            (csr_read),
    .csr_write           (csr_write),
    .csr_readdata        (csr_readdata),
    .csr_writedata       (csr_writedata),
    .pll_locked          (pll_locked),
    .rx_is_lockedtoref   (rx_is_lockedtoref),
    .rx_seriallpbken_mon (rx_seriallpbken_mon),
    .link_up             (link_up),
    .lock_lost_irq       (lock_lost_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, return at the following falling edge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic csr_wr(input logic [3:0] addr, input logic [31:0] data);
    csr_address   = addr;
    csr_writedata = data;
    csr_write     = 1'b1;
    step();
    csr_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] addr, output logic [31:0] data);
    csr_address = addr;
    csr_read    = 1'b1;
    step();
    csr_read    = 1'b0;
    data        = csr_readdata;
  endtask

  // Returns at the first falling edge where link_up is seen high
  task automatic wait_link_up(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (link_up) break;
      step();
    end
    check(tag, {31'd0, link_up}, 32'd1);
  endtask

  // Single-cycle r drop while UP; the FSM sees it two edges later
  task automatic pulse_r_loss();
    rx_is_lockedtoref = 1'b0;
    step();
    rx_is_lockedtoref = 1'b1;
    step();
  endtask

  logic [31:0] rd;
  logic        seen_up;

  initial begin
    // ---------------- reset ----------------
    step(3);
    reset = 1'b0;
    check("rst_link_up", {31'd0, link_up}, 32'd0);
    check("rst_irq", {31'd0, lock_lost_irq}, 32'd0);
    check("rst_readdata", csr_readdata, 32'd0);
    csr_rd(ADDR_STATUS, rd);
    check("rst_status", rd, 32'h0);

    // ---------------- 1: qualification timing ----------------
    // E0 = first edge sampling the high inputs; link_up expected after E18.
    pll_locked = 1'b1; rx_is_lockedtoref = 1'b1; rx_seriallpbken_mon = 1'b1;
    step(2 + QUAL);
    check("t1_link_up_early", {31'd0, link_up}, 32'd0);
    step();
    check("t1_link_up_on_time", {31'd0, link_up}, 32'd1);
    csr_rd(ADDR_STATUS, rd);
    check("t1_status", rd, 32'h2F);

    // ---------------- 2: loss, sticky, irq ----------------
    pulse_r_loss();
    step();
    check("t2_link_down", {31'd0, link_up}, 32'd0);
    csr_rd(ADDR_STATUS, rd);
    check("t2_status_holdoff", rd, 32'h3E);
    csr_rd(ADDR_LOSS, rd);
    check("t2_loss", rd, 32'd1);
    csr_rd(ADDR_STICKY, rd);
    check("t2_sticky", rd, 32'h1);
    check("t2_irq_masked", {31'd0, lock_lost_irq}, 32'd0);
    csr_wr(ADDR_CTRL, 32'h1);
    check("t2_irq_enabled", {31'd0, lock_lost_irq}, 32'd1);
    csr_rd(ADDR_CTRL, rd);
    check("t2_ctrl", rd, 32'h1);
    csr_wr(ADDR_STICKY, 32'h1);
    check("t2_irq_cleared", {31'd0, lock_lost_irq}, 32'd0);
    csr_rd(ADDR_STICKY, rd);
    check("t2_sticky_cleared", rd, 32'h0);
    wait_link_up("t2_relock", 100);

    // ---------------- 4: loopback toggle in UP ----------------
    rx_seriallpbken_mon = 1'b0;
    step(2);
    check("t4_still_up", {31'd0, link_up}, 32'd1);
    step();
    check("t4_requalify", {31'd0, link_up}, 32'd0);
    step(QUAL - 1);
    check("t4_not_yet_up", {31'd0, link_up}, 32'd0);
    step();
    check("t4_up_again", {31'd0, link_up}, 32'd1);
    csr_rd(ADDR_LOSS, rd);
    check("t4_loss_unchanged", rd, 32'd1);

    // ---------------- 3: p drops at qual count 10 ----------------
    // Toggle m to enter QUALIFY at E2; count 10 is seen after E12, so the
    // raw drop goes in before E11.
    rx_seriallpbken_mon = 1'b1;
    step(11);
    pll_locked = 1'b0;
    seen_up = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (link_up) seen_up = 1'b1;
    end
    check("t3_never_up", {31'd0, seen_up}, 32'd0);
    csr_rd(ADDR_STATUS, rd);
    check("t3_status_down", rd, 32'h0C);
    csr_rd(ADDR_LOSS, rd);
    check("t3_loss_unchanged", rd, 32'd1);
    csr_rd(ADDR_STICKY, rd);
    check("t3_sticky_clear", rd, 32'h0);
    pll_locked = 1'b1;
    wait_link_up("t3_relock", 100);

    // ---------------- 5: saturation and clear collision ----------------
    for (int k = 0; k < (1 << CNTW) + 3; k++) begin
      pulse_r_loss();
      step();
      wait_link_up("t5_relock", 100);
    end
    csr_rd(ADDR_LOSS, rd);
    check("t5_loss_saturated", rd, 32'hF);
    check("t5_irq", {31'd0, lock_lost_irq}, 32'd1);
    pulse_r_loss();
    csr_wr(ADDR_LOSS, 32'h0);   // lands on the same edge as the loss
    csr_rd(ADDR_LOSS, rd);
    check("t5_loss_clear_collision", rd, 32'd1);

    // ---------------- 6: forced relock ----------------
    wait_link_up("t6_up", 100);
    step(5);
    csr_rd(ADDR_UPTIME, rd);
    check("t6_uptime_before", rd, 32'd5);
    csr_wr(ADDR_CTRL, 32'h2);   // edge Ew: HOLDOFF entered
    check("t6_forced_down", {31'd0, link_up}, 32'd0);
    check("t6_irq_disabled", {31'd0, lock_lost_irq}, 32'd0);
    csr_rd(ADDR_STATUS, rd);    // Ew+1
    check("t6_status_holdoff", rd, 32'h3E);
    csr_rd(ADDR_CTRL, rd);      // Ew+2
    check("t6_ctrl_reads_zero", rd, 32'h0);
    step(5);                    // Ew+7
    csr_rd(ADDR_STATUS, rd);    // Ew+8: last HOLDOFF cycle
    check("t6_holdoff_last", rd, 32'h3E);
    csr_rd(ADDR_STATUS, rd);    // Ew+9: the single DOWN cycle
    check("t6_status_down", rd, 32'h0E);
    step(QUAL - 1);
    check("t6_qualifying", {31'd0, link_up}, 32'd0);
    step();
    check("t6_up_again", {31'd0, link_up}, 32'd1);
    csr_rd(ADDR_UPTIME, rd);
    check("t6_uptime_restart", rd, 32'd0);

    // ---------------- reset mid-operation ----------------
    reset = 1'b1;
    step();
    check("mid_rst_link_up", {31'd0, link_up}, 32'd0);
    check("mid_rst_readdata", csr_readdata, 32'd0);
    reset = 1'b0;
    csr_rd(ADDR_STATUS, rd);
    check("mid_rst_status", rd, 32'h0);
    csr_rd(ADDR_LOSS, rd);
    check("mid_rst_loss", rd, 32'd0);
    csr_rd(ADDR_UPTIME, rd);
    check("mid_rst_uptime", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sdi_xcvr_lock_monitor
`default_nettype wire
